// File: rtl/sync_fifo_flex_pkg.sv
// Shared types and width helpers for the single-clock flexible FIFO.
// No logic; holds the mode and prefetch-state enums.
// Widths derive from storage depth so level and pointers can reach DEPTH.
package sync_fifo_pkg;

    // Read-side presentation mode.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Output-register occupancy in first-word-fall-through mode.
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_VALID    = 2'd2
    } fwft_state_e;

    // Width needed to hold a count of 0..depth; also the pointer width,
    // since one extra bit distinguishes full from empty.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex, with thresholds and status.
// Pure wiring, no latency.
// Back-pressure is advisory (full/almost_full); the FIFO drops writes only at DEPTH.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  has_data;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic [ADDR_WIDTH:0]   af_thresh;
    logic                  overflow;
    logic                  underflow;

    // Side that produces/consumes data and sets thresholds.
    modport master (
        output wr_en, wr_data, rd_en, ae_thresh, af_thresh,
        input  full, almost_full, rd_data, empty, has_data, almost_empty,
               level, overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, rd_en, ae_thresh, af_thresh,
        output full, almost_full, rd_data, empty, has_data, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex_ram.sv
// Simple dual-port storage, one write and one registered read port.
// Read data appears one cycle after re; read-before-write on address collision.
// No back-pressure; caller guarantees address validity.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when not reading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, thresholds, level, error flags.
// Standard: data one cycle after accepted read. FWFT: first word visible two cycles after write.
// Writes accepted below DEPTH (RESERVE absorbs in-flight writes); overflow/underflow are sticky.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RESERVE    = 0,
    parameter int FWFT       = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam int         LW    = level_w(DEPTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    typedef logic [LW-1:0] ptr_t;
    typedef logic [LW-1:0] level_t;

    localparam level_t DEPTH_L = level_t'(DEPTH);
    localparam level_t FULL_AT = level_t'(DEPTH - RESERVE);

    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    level_t                level_q;
    level_t                level_nxt;
    level_t                mem_cnt;
    fwft_state_e           state;
    fwft_state_e           state_nxt;
    logic                  empty_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_q;

    // Acceptance: a read at DEPTH frees a slot so a paired write still goes in.
    always_comb begin
        rd_acc  = bus.rd_en && !empty_q;
        wr_acc  = bus.wr_en && ((level_q != DEPTH_L) || rd_acc);
        mem_cnt = wr_ptr - rd_ptr;
        unique case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + 1'b1;
            2'b01:   level_nxt = level_q - 1'b1;
            default: level_nxt = level_q;
        endcase
    end

    // RAM read issue and prefetch next-state. In FWFT the RAM output register
    // is the presentation register, so a pop reloads it on the same edge.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        if (MODE == FIFO_STD) begin
            ram_re = rd_acc;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (wr_acc) state_nxt = ST_PREFETCH;
                end
                ST_PREFETCH: begin
                    ram_re    = 1'b1;
                    state_nxt = ST_VALID;
                end
                ST_VALID: begin
                    if (rd_acc) begin
                        if (mem_cnt != '0) begin
                            ram_re = 1'b1;
                        end else if (wr_acc) begin
                            state_nxt = ST_PREFETCH;
                        end else begin
                            state_nxt = ST_EMPTY;
                        end
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Pointers, level, prefetch state and all registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            state    <= ST_EMPTY;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= (bus.af_thresh == '0);
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (ram_re) rd_ptr <= rd_ptr + 1'b1;
            level_q  <= level_nxt;
            state    <= state_nxt;
            empty_q  <= (MODE == FIFO_FWFT) ? (state_nxt != ST_VALID) : (level_nxt == '0);
            full_q   <= (level_nxt >= FULL_AT);
            afull_q  <= (level_nxt >= bus.af_thresh);
            aempty_q <= (level_nxt <= bus.ae_thresh);
            if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
            if (bus.rd_en && empty_q) udf_q <= 1'b1;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (bus.wr_data),
        .re    (ram_re),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (ram_q)
    );

    assign bus.rd_data      = ram_q;
    assign bus.empty        = empty_q;
    assign bus.has_data     = ~empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus.
// Each is compared every cycle against a queue model; FWFT visibility uses write timestamps.
// Directed phases follow the reset, fill, underflow, latency, threshold and streaming cases.
module tb_sync_fifo_flex;
    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int RESERVE = 2;
    localparam int AE      = 1;
    localparam int AF      = 12;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   ae_thresh = AE[AW:0];
    logic [AW:0]   af_thresh = AF[AW:0];

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_if ();
    sync_fifo_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f_if ();

    assign s_if.wr_en     = wr_en;
    assign s_if.wr_data   = wr_data;
    assign s_if.rd_en     = rd_en;
    assign s_if.ae_thresh = ae_thresh;
    assign s_if.af_thresh = af_thresh;
    assign f_if.wr_en     = wr_en;
    assign f_if.wr_data   = wr_data;
    assign f_if.rd_en     = rd_en;
    assign f_if.ae_thresh = ae_thresh;
    assign f_if.af_thresh = af_thresh;

    sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESERVE(RESERVE), .FWFT(0))
        u_std (.clk(clk), .rst_n(rst_n), .bus(s_if));
    sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESERVE(RESERVE), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(f_if));

    typedef struct {
        logic [DW-1:0] d;
        int            w;
    } ent_t;

    logic [DW-1:0] q_s[$];
    ent_t          q_f[$];
    logic [DW-1:0] rdd_s = '0;
    bit            ovf_s, udf_s, ovf_f, udf_f;
    int            ecount = 0;
    int            n_chk  = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Head is presentable once it is at the front and at least two edges
    // have passed since its write edge.
    function automatic bit fw_vis();
        if (q_f.size() == 0) return 1'b0;
        return ecount >= q_f[0].w + 2;
    endfunction

    task automatic model_edge();
        bit rs, ws, rf, wf;
        if (!rst_n) begin
            q_s.delete();
            q_f.delete();
            rdd_s = '0;
            ovf_s = 0; udf_s = 0; ovf_f = 0; udf_f = 0;
        end else begin
            rs = rd_en && (q_s.size() > 0);
            ws = wr_en && ((q_s.size() < DEPTH) || rs);
            if (rd_en && !rs) udf_s = 1;
            if (wr_en && !ws) ovf_s = 1;
            if (rs) rdd_s = q_s.pop_front();
            if (ws) q_s.push_back(wr_data);

            rf = rd_en && fw_vis();
            wf = wr_en && ((q_f.size() < DEPTH) || rf);
            if (rd_en && !rf) udf_f = 1;
            if (wr_en && !wf) ovf_f = 1;
            if (rf) void'(q_f.pop_front());
            if (wf) q_f.push_back('{d: wr_data, w: ecount});
        end
        ecount++;
    endtask

    task automatic check_all();
        chk("std.level",  32'(s_if.level),   q_s.size());
        chk("std.empty",  s_if.empty,        q_s.size() == 0);
        chk("std.hasdat", s_if.has_data,     q_s.size() != 0);
        chk("std.full",   s_if.full,         q_s.size() >= DEPTH - RESERVE);
        chk("std.afull",  s_if.almost_full,  q_s.size() >= AF);
        chk("std.aempty", s_if.almost_empty, q_s.size() <= AE);
        chk("std.ovf",    s_if.overflow,     ovf_s);
        chk("std.udf",    s_if.underflow,    udf_s);
        chk("std.rdata",  s_if.rd_data,      rdd_s);
        chk("fw.level",   32'(f_if.level),   q_f.size());
        chk("fw.empty",   f_if.empty,        !fw_vis());
        chk("fw.hasdat",  f_if.has_data,     fw_vis());
        chk("fw.full",    f_if.full,         q_f.size() >= DEPTH - RESERVE);
        chk("fw.afull",   f_if.almost_full,  q_f.size() >= AF);
        chk("fw.aempty",  f_if.almost_empty, q_f.size() <= AE);
        chk("fw.ovf",     f_if.overflow,     ovf_f);
        chk("fw.udf",     f_if.underflow,    udf_f);
        if (fw_vis()) chk("fw.rdata", f_if.rd_data, q_f[0].d);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values with a write request held during reset
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h33;
        repeat (5) cycle();
        chk("rst.empty",  s_if.empty, 1);
        chk("rst.hasdat", s_if.has_data, 0);
        chk("rst.level",  32'(s_if.level), 0);
        chk("rst.ovf",    s_if.overflow, 0);
        chk("rst.udf",    s_if.underflow, 0);
        chk("rst.rdata",  s_if.rd_data, 0);
        chk("rst.fw.empty", f_if.empty, 1);
        wr_en = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Fill to DEPTH, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = i[DW-1:0];
            cycle();
            chk("fill.full", s_if.full, (i + 1) >= DEPTH - RESERVE);
        end
        wr_data = 8'hFF;
        cycle();
        wr_en = 1'b0;
        chk("fill.ovf",   s_if.overflow, 1);
        chk("fill.level", 32'(s_if.level), DEPTH);
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            chk("drain.data", s_if.rd_data, i);
        end
        rd_en = 1'b0;
        cycle();
        chk("drain.empty", s_if.empty, 1);

        // Simultaneous read and write on an empty FIFO
        do_reset();
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAB;
        cycle();
        chk("uf.udf",   s_if.underflow, 1);
        chk("uf.level", 32'(s_if.level), 1);
        rd_en = 1'b0;
        wr_en = 1'b0;
        cycle();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("uf.rdata", s_if.rd_data, 8'hAB);
        chk("uf.empty", s_if.empty, 1);

        // FWFT first-word latency and full-rate pops
        do_reset();
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        cycle();
        wr_en = 1'b0;
        chk("fwlat.empty0", f_if.empty, 1);
        cycle();
        chk("fwlat.empty1", f_if.empty, 0);
        chk("fwlat.rdata",  f_if.rd_data, 8'h5A);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = i[DW-1:0];
            cycle();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("fwpop.data",  f_if.rd_data, i);
            chk("fwpop.empty", f_if.empty, 0);
            cycle();
        end
        rd_en = 1'b0;
        chk("fwpop.done", f_if.empty, 1);

        // Threshold edges
        do_reset();
        for (int lvl = 0; lvl <= AF; lvl++) begin
            chk("thr.aempty", s_if.almost_empty, lvl <= AE);
            chk("thr.afull",  s_if.almost_full,  lvl >= AF);
            if (lvl < AF) begin
                wr_en   = 1'b1;
                wr_data = 8'(lvl + 8'h40);
                cycle();
            end
        end
        wr_en = 1'b0;

        // Sustained random streaming
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1) && (q_s.size() < DEPTH) && (q_f.size() < DEPTH);
            rd_en   = ($urandom_range(0, 1) == 1) && (q_s.size() > 0) && fw_vis();
            wr_data = 8'($urandom);
            cycle();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 4 * DEPTH && (q_s.size() > 0 || q_f.size() > 0); k++) begin
            rd_en = fw_vis();
            cycle();
        end
        rd_en = 1'b0;
        cycle();
        chk("stream.std.ovf", s_if.overflow, 0);
        chk("stream.std.udf", s_if.underflow, 0);
        chk("stream.fw.ovf",  f_if.overflow, 0);
        chk("stream.fw.udf",  f_if.underflow, 0);
        chk("stream.std.lvl", 32'(s_if.level), 0);
        chk("stream.fw.lvl",  32'(f_if.level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
